// File: rtl/ocp_burst_master.sv
// OCP burst master: turns bridge-side burst requests into precise INCR OCP bursts.
// Writes are posted; reads forward each response beat to the bridge with error tracking.
module ocp_burst_master #(
    parameter int ADDR_WDTH  = 64,
    parameter int DATA_WDTH  = 8,
    parameter int BURST_WDTH = 8
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WDTH-1:0]  req_addr,
    input  logic [BURST_WDTH-1:0] req_len,
    input  logic                  wr_data_valid,
    input  logic [DATA_WDTH-1:0]  wr_data,
    output logic                  wr_data_ready,
    output logic                  rd_data_valid,
    output logic [DATA_WDTH-1:0]  rd_data,
    input  logic                  rd_ready,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WDTH-1:0]  MAddr,
    output logic [2:0]            MCmd,
    output logic [BURST_WDTH-1:0] MBurstLength,
    output logic [DATA_WDTH-1:0]  MData,
    output logic                  MDataValid,
    output logic                  MDataLast,
    output logic                  MRespAccept,
    input  logic                  SCmdAccept,
    input  logic                  SDataAccept,
    input  logic [DATA_WDTH-1:0]  SData,
    input  logic [1:0]            SResp,
    input  logic                  SRespLast
);

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [BURST_WDTH-1:0] ONE = BURST_WDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [BURST_WDTH-1:0] cnt_q, cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic [ADDR_WDTH-1:0]  maddr_d;
    logic [2:0]            mcmd_d;
    logic [BURST_WDTH-1:0] mlen_d;
    logic [DATA_WDTH-1:0]  mdata_d;
    logic                  mvalid_d;
    logic                  mlast_d;
    logic                  done_d;
    logic                  err_d;
    logic                  last_idx;

    // MBurstLength doubles as the latched burst length for the whole transaction.
    assign last_idx = (cnt_q == MBurstLength - ONE);
    assign rd_data  = SData;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_flag_d    = err_flag_q;
        maddr_d       = MAddr;
        mcmd_d        = MCmd;
        mlen_d        = MBurstLength;
        mdata_d       = MData;
        mvalid_d      = MDataValid;
        mlast_d       = MDataLast;
        req_ready     = 1'b0;
        wr_data_ready = 1'b0;
        rd_data_valid = 1'b0;
        MRespAccept   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_len != '0) begin
                        maddr_d    = req_addr;
                        mlen_d     = req_len;
                        cnt_d      = '0;
                        err_flag_d = 1'b0;
                        mcmd_d     = req_write ? CMD_WR : CMD_RD;
                        state_d    = req_write ? WR_REQ : RD_REQ;
                    end else begin
                        err_flag_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end

            WR_REQ: begin
                if (SCmdAccept) begin
                    mcmd_d  = CMD_IDLE;
                    state_d = WR_DATA;
                end
            end

            WR_DATA: begin
                // Stop pulling beats once len have been taken; the last one may still be in MData.
                wr_data_ready = (cnt_q != MBurstLength) && (!MDataValid || SDataAccept);
                if (MDataValid && SDataAccept) begin
                    mvalid_d = 1'b0;
                    mlast_d  = 1'b0;
                    if (MDataLast) begin
                        state_d = DONE;
                    end
                end
                if (wr_data_valid && wr_data_ready) begin
                    mdata_d  = wr_data;
                    mvalid_d = 1'b1;
                    mlast_d  = last_idx;
                    cnt_d    = cnt_q + ONE;
                end
            end

            RD_REQ: begin
                if (SCmdAccept) begin
                    mcmd_d  = CMD_IDLE;
                    state_d = RD_RESP;
                end
            end

            RD_RESP: begin
                MRespAccept   = rd_ready;
                rd_data_valid = (SResp != RESP_NULL);
                if (rd_data_valid && rd_ready) begin
                    cnt_d = cnt_q + ONE;
                    if (SResp[1] || (SRespLast != last_idx)) begin
                        err_flag_d = 1'b1;
                    end
                    if (last_idx) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        err_d  = (state_d == DONE) && err_flag_d;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            MAddr        <= '0;
            MCmd         <= CMD_IDLE;
            MBurstLength <= '0;
            MData        <= '0;
            MDataValid   <= 1'b0;
            MDataLast    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            MAddr        <= maddr_d;
            MCmd         <= mcmd_d;
            MBurstLength <= mlen_d;
            MData        <= mdata_d;
            MDataValid   <= mvalid_d;
            MDataLast    <= mlast_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

endmodule
